// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: commit-side controller driving the CSR file for Zicsr accesses
// and sequencing trap entry / mret with a PC redirect and pipeline flush.
module csr_trap_ctrl #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned ECODE_W = 63
) (
    input  logic               clk,
    input  logic               rst_n,
    // retiring instruction from writeback
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [2:0]         in_kind,
    input  logic [2:0]         in_funct3,
    input  logic [11:0]        in_csr_addr,
    input  logic [4:0]         in_rs1_idx,
    input  logic [XLEN-1:0]    in_rs1_val,
    input  logic [4:0]         in_rd_idx,
    // CSR file access
    output logic               csr_re,
    output logic [11:0]        csr_num,
    output logic               csr_we,
    output logic [XLEN-1:0]    csr_wmask,
    output logic [XLEN-1:0]    csr_wvalue,
    input  logic [XLEN-1:0]    csr_rvalue,
    // trap / return strobes
    output logic               ex,
    output logic               ex_ret,
    output logic [XLEN-1:0]    epc,
    output logic [ECODE_W-1:0] ecode,
    input  logic [XLEN-1:0]    ex_entry,
    // register-file writeback of the old CSR value
    output logic               rd_wen,
    output logic [4:0]         rd_waddr,
    output logic [XLEN-1:0]    rd_wdata,
    // fetch redirect
    output logic               flush,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc,
    input  logic               redirect_ready
);

    localparam int unsigned CSR_ADDR_W = 12;
    localparam int unsigned REG_IDX_W  = 5;

    localparam logic [2:0] KIND_NORMAL = 3'd0;
    localparam logic [2:0] KIND_CSR    = 3'd1;
    localparam logic [2:0] KIND_ECALL  = 3'd2;
    localparam logic [2:0] KIND_EBREAK = 3'd3;
    localparam logic [2:0] KIND_MRET   = 3'd4;

    localparam logic [ECODE_W-1:0] ECODE_ILLEGAL = ECODE_W'(2);
    localparam logic [ECODE_W-1:0] ECODE_EBREAK  = ECODE_W'(3);
    localparam logic [ECODE_W-1:0] ECODE_ECALL   = ECODE_W'(11);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CSR_ACC    = 3'd1,
        ST_TRAP       = 3'd2,
        ST_TRAP_REDIR = 3'd3,
        ST_RET        = 3'd4,
        ST_RET_REDIR  = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic                    in_ready_q, in_ready_d;
    logic                    csr_re_q, csr_re_d;
    logic                    csr_we_q, csr_we_d;
    logic [CSR_ADDR_W-1:0]   csr_num_q, csr_num_d;
    logic [XLEN-1:0]         csr_wmask_q, csr_wmask_d;
    logic [XLEN-1:0]         csr_wvalue_q, csr_wvalue_d;
    logic                    ex_q, ex_d;
    logic                    ex_ret_q, ex_ret_d;
    logic [XLEN-1:0]         epc_q, epc_d;
    logic [ECODE_W-1:0]      ecode_q, ecode_d;
    logic                    rd_wen_q, rd_wen_d;
    logic [REG_IDX_W-1:0]    rd_waddr_q, rd_waddr_d;
    logic                    flush_q, flush_d;
    logic                    redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]         redirect_pc_q, redirect_pc_d;

    logic                    accept;
    logic                    take_trap;
    logic [ECODE_W-1:0]      trap_code;
    logic [XLEN-1:0]         src;

    // Next-state and next-output decode; strobes default low, payloads hold.
    always_comb begin
        state_d          = state_q;
        csr_re_d         = 1'b0;
        csr_we_d         = 1'b0;
        ex_d             = 1'b0;
        ex_ret_d         = 1'b0;
        rd_wen_d         = 1'b0;
        flush_d          = 1'b0;
        csr_num_d        = csr_num_q;
        csr_wmask_d      = csr_wmask_q;
        csr_wvalue_d     = csr_wvalue_q;
        epc_d            = epc_q;
        ecode_d          = ecode_q;
        rd_waddr_d       = rd_waddr_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        take_trap        = 1'b0;
        trap_code        = '0;
        accept           = in_valid && in_ready_q;
        src              = in_funct3[2] ? XLEN'(in_rs1_idx) : in_rs1_val;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (in_kind)
                        KIND_NORMAL: ;
                        KIND_CSR: begin
                            if (in_funct3[1:0] != 2'b00) begin
                                state_d    = ST_CSR_ACC;
                                csr_num_d  = in_csr_addr;
                                rd_waddr_d = in_rd_idx;
                                rd_wen_d   = (in_rd_idx != '0);
                                if (in_funct3[1:0] == 2'b01) begin
                                    // RW: write-only when rd is x0
                                    csr_re_d     = (in_rd_idx != '0);
                                    csr_we_d     = 1'b1;
                                    csr_wmask_d  = '1;
                                    csr_wvalue_d = src;
                                end else begin
                                    // RS/RC: read-only when rs1 field is zero
                                    csr_re_d     = 1'b1;
                                    csr_we_d     = (in_rs1_idx != '0);
                                    csr_wmask_d  = src;
                                    csr_wvalue_d = (in_funct3[1:0] == 2'b10) ? '1 : '0;
                                end
                            end else begin
                                take_trap = 1'b1;
                                trap_code = ECODE_ILLEGAL;
                            end
                        end
                        KIND_ECALL: begin
                            take_trap = 1'b1;
                            trap_code = ECODE_ECALL;
                        end
                        KIND_EBREAK: begin
                            take_trap = 1'b1;
                            trap_code = ECODE_EBREAK;
                        end
                        KIND_MRET: begin
                            state_d  = ST_RET;
                            ex_ret_d = 1'b1;
                            flush_d  = 1'b1;
                        end
                        default: begin
                            take_trap = 1'b1;
                            trap_code = ECODE_ILLEGAL;
                        end
                    endcase
                    if (take_trap) begin
                        state_d = ST_TRAP;
                        ex_d    = 1'b1;
                        flush_d = 1'b1;
                        epc_d   = in_pc;
                        ecode_d = trap_code;
                    end
                end
            end
            ST_CSR_ACC: state_d = ST_IDLE;
            ST_TRAP:    state_d = ST_TRAP_REDIR;
            ST_TRAP_REDIR: begin
                // ex_entry reflects the new mcause only after the ex edge,
                // so it is sampled here rather than during TRAP.
                if (!redirect_valid_q) begin
                    redirect_pc_d    = ex_entry;
                    redirect_valid_d = 1'b1;
                end else if (redirect_ready) begin
                    redirect_valid_d = 1'b0;
                    state_d          = ST_IDLE;
                end
            end
            ST_RET: begin
                // csr_rvalue returns mepc while ex_ret is asserted
                redirect_pc_d    = csr_rvalue;
                redirect_valid_d = 1'b1;
                state_d          = ST_RET_REDIR;
            end
            ST_RET_REDIR: begin
                if (redirect_ready) begin
                    redirect_valid_d = 1'b0;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            in_ready_q       <= 1'b0;
            csr_re_q         <= 1'b0;
            csr_we_q         <= 1'b0;
            csr_num_q        <= '0;
            csr_wmask_q      <= '0;
            csr_wvalue_q     <= '0;
            ex_q             <= 1'b0;
            ex_ret_q         <= 1'b0;
            epc_q            <= '0;
            ecode_q          <= '0;
            rd_wen_q         <= 1'b0;
            rd_waddr_q       <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            in_ready_q       <= in_ready_d;
            csr_re_q         <= csr_re_d;
            csr_we_q         <= csr_we_d;
            csr_num_q        <= csr_num_d;
            csr_wmask_q      <= csr_wmask_d;
            csr_wvalue_q     <= csr_wvalue_d;
            ex_q             <= ex_d;
            ex_ret_q         <= ex_ret_d;
            epc_q            <= epc_d;
            ecode_q          <= ecode_d;
            rd_wen_q         <= rd_wen_d;
            rd_waddr_q       <= rd_waddr_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign csr_re         = csr_re_q;
    assign csr_we         = csr_we_q;
    assign csr_num        = csr_num_q;
    assign csr_wmask      = csr_wmask_q;
    assign csr_wvalue     = csr_wvalue_q;
    assign ex             = ex_q;
    assign ex_ret         = ex_ret_q;
    assign epc            = epc_q;
    assign ecode          = ecode_q;
    assign rd_wen         = rd_wen_q;
    assign rd_waddr       = rd_waddr_q;
    // old CSR value is read back in the access cycle itself
    assign rd_wdata       = rd_wen_q ? csr_rvalue : '0;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
Commit-side controller that sits directly upstream of the CSR register file. It accepts one retiring instruction at a time from the writeback stage. For Zicsr instructions it drives the CSR file's read/write/mask interface. For ecall/ebreak/illegal/mret it sequences the ex/ex_ret strobes and issues a PC redirect plus a pipeline flush to the fetch stage. It consumes csr_rvalue and ex_entry from the CSR file.

Parameters:
XLEN, 64, datapath width (CSR interface fixed at 64).
ECODE_W, 63, exception code width (matches CSR file mcause_code).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  writeback offers a retiring instruction
in_ready  output  1  controller can accept (high only in IDLE)
in_pc  input  64  PC of the instruction
in_kind  input  3  0=normal,1=csr,2=ecall,3=ebreak,4=mret,5=illegal; 6,7 treated as illegal
in_funct3  input  3  Zicsr funct3
in_csr_addr  input  12  CSR number
in_rs1_idx  input  5  rs1 index / uimm field
in_rs1_val  input  64  rs1 value
in_rd_idx  input  5  destination register
csr_re  output  1  to CSR file
csr_num  output  12  to CSR file
csr_we  output  1  to CSR file
csr_wmask  output  64  to CSR file
csr_wvalue  output  64  to CSR file
csr_rvalue  input  64  from CSR file (returns mepc while ex_ret=1)
ex  output  1  trap strobe to CSR file
ex_ret  output  1  mret strobe to CSR file
epc  output  64  faulting PC
ecode  output  63  trap cause
ex_entry  input  64  trap vector from CSR file
rd_wen  output  1  one-cycle register-file write pulse
rd_waddr  output  5  destination
rd_wdata  output  64  old CSR value
flush  output  1  one-cycle pipeline flush pulse
redirect_valid  output  1  new PC offered to fetch
redirect_pc  output  64  target PC
redirect_ready  input  1  fetch accepts redirect

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All strobes low: csr_re, csr_we, ex, ex_ret, rd_wen, flush, redirect_valid. Latched fields, redirect_pc, rd_wdata, epc, ecode, csr_num, csr_wmask, csr_wvalue all 0. Reset mid-operation aborts any access or redirect with no pending state retained.
- Accept: in_valid & in_ready on a rising edge latches all in_* fields. kind 0 completes in that cycle and state stays IDLE.
- States: IDLE, CSR_ACC, TRAP, TRAP_REDIR, RET, RET_REDIR.
- IDLE -> CSR_ACC when kind=1 and funct3 is in {1,2,3,5,6,7}. funct3 0 or 4 is treated as illegal.
- CSR_ACC (exactly 1 cycle):
  - csr_num = latched address.
  - src = rs1_val for funct3[2]=0; otherwise {59'b0, rs1_idx}.
  - RW: wmask = all ones, wvalue = src.
  - RS: wmask = src, wvalue = all ones.
  - RC: wmask = src, wvalue = 0.
  - csr_re = 0 only for RW/RWI with rd_idx=0.
  - csr_we = 0 for RS/RC/RSI/RCI with rs1_idx=0.
  - Same cycle: rd_wen = (rd_idx!=0), rd_wdata = csr_rvalue (pre-write value).
  - Next state IDLE.
- IDLE -> TRAP for ecall (ecode 11), ebreak (3), or illegal (2).
- TRAP (1 cycle): ex=1, epc = latched pc, flush=1. Next state TRAP_REDIR.
- TRAP_REDIR: on entry, redirect_pc is captured from ex_entry, which is valid one cycle after ex because mcause updates on that edge. redirect_valid is held high until redirect_ready, then state returns to IDLE. redirect_pc must stay stable while valid.
- IDLE -> RET for mret.
- RET (1 cycle): ex_ret=1, csr_re=0, flush=1, redirect_pc <= csr_rvalue (mepc). Next state RET_REDIR, which follows the same handshake as TRAP_REDIR.
- ex and ex_ret are never high together. csr_we is never high while ex is high.
- redirect_valid & redirect_ready completes in the same cycle, and in_ready rises the following cycle.
- ecode is zero-extended to 63 bits. mcause_intr is never produced.

Test Plan:
- csrrw x5, mtvec(0x305), rs1_val=0x8000_0100 -> CSR_ACC cycle: csr_we=1, wmask=all ones, wvalue=0x8000_0100, rd_wen=1, rd_waddr=5, rd_wdata = prior mtvec; in_ready low for exactly 1 cycle.
- csrrs x0, mstatus, rs1_idx=0 -> csr_we=0, csr_re=1, rd_wen=0. csrrci x3, mepc, uimm=0x1F -> wmask=0x1F, wvalue=0.
- ecall at pc=0x8000_0040, mtvec=0x8000_1000 -> ex pulse with epc=0x8000_0040, ecode=11, flush pulse; next cycle redirect_pc=0x8000_1000; redirect_ready held low 3 cycles keeps valid and pc stable.
- mret with mepc=0x8000_0044 -> ex_ret pulse, redirect_pc=0x8000_0044, ex never asserted.
- in_kind=1 with funct3=4 -> behaves as illegal: ecode=2, CSR file not written.
- rst_n low during TRAP_REDIR -> all outputs 0 immediately (async); after release, in_ready=1 and no redirect is reissued.
